// File: rtl/wb_ram_bridge.sv
// Wishbone classic slave driving a single-port synchronous RAM, with RMW for partial writes.
// Optional WB_RAM_BRIDGE_ERR_EN: refused accesses end with wb_err_o instead of wb_ack_o.
module wb_ram_bridge #(
  parameter logic [31:0] ADDR_LOW  = 32'h0000_0000,
  parameter logic [31:0] ADDR_HIGH = 32'h0000_0fff,
  parameter logic        READ_ONLY = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic        ram_wren_o,
  input  logic [31:0] ram_data_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    MERGE,
    WR,
    ACK,
    ERR
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic [31:0] merged;
  logic [31:0] word_adr;
  logic        in_range;
  logic        refuse;
  logic        req;
  logic        unused_adr;

  assign word_adr   = {2'b00, wb_adr_i[31:2]};
  assign unused_adr = ^wb_adr_i[1:0];
  assign in_range   = (word_adr >= ADDR_LOW) &&
                      (word_adr <= ADDR_HIGH);
  assign refuse     = !in_range ||
                      (wb_we_i && READ_ONLY);
  assign req        = wb_cyc_i & wb_stb_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (refuse) begin
`ifdef WB_RAM_BRIDGE_ERR_EN
            state_d = ERR;
`else
            state_d = ACK;
`endif
          end else if (!wb_we_i) begin
            state_d = RD_ADDR;
          end else if (wb_sel_i == 4'hF ||
                       wb_sel_i == 4'h0) begin
            state_d = WR;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (!wb_cyc_i)  state_d = IDLE;
        else if (we_q)  state_d = MERGE;
        else            state_d = RD_DATA;
      end
      RD_DATA,
      MERGE,
      WR: begin
        if (!wb_cyc_i) state_d = IDLE;
        else           state_d = ACK;
      end
      ACK,
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      dat_q      <= 32'h0;
      ram_addr_o <= 32'h0;
      wb_dat_o   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        we_q       <= wb_we_i;
        sel_q      <= wb_sel_i;
        dat_q      <= wb_dat_i;
        ram_addr_o <= word_adr;
`ifndef WB_RAM_BRIDGE_ERR_EN
        if (refuse && !wb_we_i)
          wb_dat_o <= 32'h0;
`endif
      end
      if (state_q == RD_DATA && wb_cyc_i)
        wb_dat_o <= ram_data_i;
    end
  end

  // byte lanes not selected keep the word just read from RAM
  always_comb begin
    merged = ram_data_i;
    for (int n = 0; n < 4; n++) begin
      if (sel_q[n])
        merged[8*n +: 8] = dat_q[8*n +: 8];
    end
  end

  assign ram_data_o = (state_q == MERGE) ? merged : dat_q;
  assign ram_wren_o = wb_cyc_i &
                      (((state_q == WR) && (sel_q != 4'h0)) ||
                       (state_q == MERGE));
  assign wb_ack_o   = (state_q == ACK);
`ifdef WB_RAM_BRIDGE_ERR_EN
  assign wb_err_o   = (state_q == ERR);
`else
  assign wb_err_o   = 1'b0;
`endif

endmodule

// File: doc/wb_ram_bridge.md
Name: wb_ram_bridge

Overview:
- Wishbone classic slave that acts as the initiator for the single-port synchronous RAM (`ram`) in the ram_wb subsystem.
- Converts 32-bit byte-addressed Wishbone cycles into RAM word accesses.
- The RAM has one cycle of read latency and no byte enables, so partial-word writes are done as read-modify-write.
- Sits between the CPU data bus and one `ram` instance; RAM-side ports connect 1:1 to the RAM's data_i/addr_i/wren_i/data_o.

Parameters:
- ADDR_LOW, 32'h00000000, lowest valid RAM word address; must match the RAM's addr_low.
- ADDR_HIGH, 32'h00000fff, highest valid RAM word address; must match the RAM's addr_high.
- READ_ONLY, 1'b0, when 1 every write is refused and the RAM is never written.

Ports:
- clk_i  in  1  clock; every register updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  32  byte address; bits [1:0] ignored.
- wb_sel_i  in  4  byte lane enables; bit n covers data bits [8n+7:8n].
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  one-cycle acknowledge.
- wb_err_o  out  1  one-cycle error; driven only when the optional feature is compiled in.
- ram_addr_o  out  32  RAM word address = {2'b00, latched wb_adr_i[31:2]}.
- ram_data_o  out  32  RAM write data.
- ram_wren_o  out  1  RAM write enable.
- ram_data_i  in  32  RAM read data; valid the cycle after ram_addr_o is presented.

Behaviour:
- Clocking and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state=IDLE; wb_ack_o=0; wb_err_o=0; wb_dat_o=0; ram_wren_o=0; ram_addr_o=0; ram_data_o=0.
- Reset mid-transaction: abandons it, no ack and no RAM write on the following cycles.
- FSM states: IDLE, RD_ADDR, RD_DATA, MERGE, WR, ACK, ERR.
- Request sampling (call this edge E0): in IDLE, with wb_cyc_i & wb_stb_i, latch address, we, sel and data.
- Range check: word address wa = wb_adr_i[31:2]; in range iff ADDR_LOW <= wa <= ADDR_HIGH, 32-bit unsigned compare.
- Read, in range: IDLE -> RD_ADDR (RAM address presented, wren=0) -> RD_DATA (ram_data_i valid; wb_dat_o <= ram_data_i at the edge) -> ACK. wb_ack_o is high in the 3rd cycle after E0.
- Full write (sel=4'hF): IDLE -> WR (ram_wren_o=1, ram_data_o=wb data) -> ACK. Ack in the 2nd cycle after E0.
- Partial write (sel neither 4'hF nor 4'h0): IDLE -> RD_ADDR -> MERGE -> ACK. Ack in the 3rd cycle after E0.
  - In MERGE: ram_wren_o=1; ram_data_o lane n = sel[n] ? wb data lane n : ram_data_i lane n, merged combinationally.
- Write with sel=4'h0: IDLE -> WR with ram_wren_o held 0 -> ACK. No RAM change.
- ACK: wb_ack_o=1 for exactly one cycle, then IDLE; stb is ignored during ACK, so no double trigger.
  - Back-to-back requests restart at the next IDLE edge.
- wb_dat_o: updates only on reads and holds its value otherwise.
- ram_wren_o: asserted only in WR and MERGE, and gated by wb_cyc_i in that same cycle.
- Abort: wb_cyc_i low in any non-IDLE, non-ACK/ERR state returns the FSM to IDLE next edge with no ack; any write in that cycle is suppressed.
- Out of range or READ_ONLY write: handled as described under Optional Feature.
- No pipelining: only one transaction is outstanding at a time.

Optional Feature:
- Macro: WB_RAM_BRIDGE_ERR_EN.
- Defined: an out-of-range access, or any write when READ_ONLY=1, goes IDLE -> ERR -> IDLE.
  - wb_err_o=1 for one cycle, in the 1st cycle after E0; wb_ack_o stays 0.
  - No RAM write; wb_dat_o unchanged.
- Undefined: wb_err_o is tied to 0 and the same accesses go IDLE -> ACK -> IDLE.
  - Ack in the 1st cycle after E0.
  - Reads return wb_dat_o=0; writes are silently dropped.

Test Plan:
- Reset and idle: assert rst_i for 2 cycles -> all outputs 0; no ack while stb is low.
- Full write then read: write adr=0x10, dat=0xDEADBEEF, sel=F -> ram_wren_o=1 with ram_addr_o=4; ack at E0+2. Then read 0x10 -> ack at E0+3 with wb_dat_o=0xDEADBEEF.
- Partial write: word 4 holds 0xDEADBEEF; write dat=0x11223344, sel=4'b0101 -> MERGE writes 0xDE22BE44; ack at E0+3; a read back returns 0xDE22BE44.
- Abort: start a partial write, drop wb_cyc_i in RD_ADDR -> no ack, ram_wren_o never 1, word unchanged.
- Out of range: read adr=0x4000 (word 0x1000) with the defaults. With WB_RAM_BRIDGE_ERR_EN -> wb_err_o at E0+1 and no ack; without -> ack at E0+1 with wb_dat_o=0.
- READ_ONLY=1, full write to 0x10 -> RAM unchanged; err (macro defined) or ack (macro undefined) at E0+1.
